// File: rtl/draw_pkt_serializer.sv
// Frames one drawing sample as SYNC byte + payload bytes (LSB byte first), suppressing repeats of the last sent sample.
// Define DRAW_PKT_CHECKSUM_EN to append an XOR-of-payload checksum byte after the payload.
module draw_pkt_serializer #(
  parameter int unsigned X_WIDTH     = 9,
  parameter int unsigned Y_WIDTH     = 8,
  parameter int unsigned COLOR_WIDTH = 3,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [X_WIDTH-1:0]     x_in,
  input  logic [Y_WIDTH-1:0]     y_in,
  input  logic [COLOR_WIDTH-1:0] color_in,
  input  logic                   pen_down_in,
  input  logic                   sample_valid_in,
  output logic                   sample_ready_out,
  output logic [7:0]             byte_out,
  output logic                   byte_valid_out,
  input  logic                   byte_ready_in,
  output logic                   frame_done_out,
  output logic                   dropped_out
);

  localparam int unsigned PW        = X_WIDTH + Y_WIDTH + COLOR_WIDTH + 1;
  localparam int unsigned NUM_BYTES = (PW + 7) / 8;
  localparam int unsigned BW        = NUM_BYTES * 8;
  localparam int unsigned CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

`ifdef DRAW_PKT_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PAYLOAD, S_CSUM} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_PAYLOAD} state_t;
`endif

  state_t           state_q, state_d;
  logic [PW-1:0]    sample_w;
  logic [PW-1:0]    last_q, last_d;
  logic             last_valid_q, last_valid_d;
  logic [BW-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             accept;
  logic             take;
`ifdef DRAW_PKT_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  assign sample_w         = {pen_down_in, color_in, y_in, x_in};
  assign sample_ready_out = (state_q == S_IDLE);
  assign accept           = sample_valid_in & sample_ready_out;
  assign take             = byte_valid_q & byte_ready_in;

  assign byte_out       = byte_q;
  assign byte_valid_out = byte_valid_q;
  assign frame_done_out = done_q;
  assign dropped_out    = drop_q;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    last_valid_d = last_valid_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    done_d       = 1'b0;
    drop_d       = 1'b0;
`ifdef DRAW_PKT_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (last_valid_q && (sample_w == last_q)) begin
            drop_d = 1'b1;
          end else begin
            state_d      = S_SYNC;
            last_d       = sample_w;
            last_valid_d = 1'b1;
            shift_d      = BW'(sample_w);
            cnt_d        = '0;
            byte_d       = SYNC_BYTE;
            byte_valid_d = 1'b1;
`ifdef DRAW_PKT_CHECKSUM_EN
            csum_d       = '0;
`endif
          end
        end
      end
      S_SYNC: begin
        if (take) begin
          state_d = S_PAYLOAD;
          byte_d  = shift_q[7:0];
          shift_d = shift_q >> 8;
        end
      end
      S_PAYLOAD: begin
        if (take) begin
`ifdef DRAW_PKT_CHECKSUM_EN
          csum_d = csum_q ^ byte_q;
`endif
          if (cnt_q == LAST_CNT) begin
`ifdef DRAW_PKT_CHECKSUM_EN
            state_d = S_CSUM;
            byte_d  = csum_q ^ byte_q;
`else
            state_d      = S_IDLE;
            byte_valid_d = 1'b0;
            done_d       = 1'b1;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            byte_d  = shift_q[7:0];
            shift_d = shift_q >> 8;
          end
        end
      end
`ifdef DRAW_PKT_CHECKSUM_EN
      S_CSUM: begin
        if (take) begin
          state_d      = S_IDLE;
          byte_valid_d = 1'b0;
          done_d       = 1'b1;
        end
      end
`endif
      default: begin
        state_d      = S_IDLE;
        byte_valid_d = 1'b0;
      end
    endcase
  end

  // Reset aborts any frame in flight and forgets the last sample, so the next one is always sent.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      last_q       <= '0;
      last_valid_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
      drop_q       <= 1'b0;
`ifdef DRAW_PKT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      last_valid_q <= last_valid_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
      drop_q       <= drop_d;
`ifdef DRAW_PKT_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule
